// File: rtl/mem_access_unit.sv
// RV32I memory-stage load/store unit: issues one req/ready bus access per M-stage
// load/store, stalls the pipeline until it completes, and returns the extended load result.
module mem_access_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            M_valid,
  input  logic            M_mem_rd,
  input  logic            M_mem_wr,
  input  logic [2:0]      M_funct3,
  input  logic [XLEN-1:0] M_addr,
  input  logic [XLEN-1:0] M_store_data,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_wstrb,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_ready,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata,
  output logic            waiting,
  output logic [XLEN-1:0] ld_data,
  output logic            mem_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]      state;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic            mem_op;
  logic            misalign;
  logic            bad_f3;
  logic            issue;
  logic [3:0]      st_strb;
  logic [XLEN-1:0] st_data;
  logic [XLEN-1:0] rd_shift;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [XLEN-1:0] ld_ext;

  // A load wins when both rd and wr are set, so M_mem_rd alone selects the direction.
  always_comb begin
    mem_op   = M_valid & (M_mem_rd | M_mem_wr);
    misalign = ((M_funct3[1:0] == 2'b01) & M_addr[0]) |
               ((M_funct3[1:0] == 2'b10) & (M_addr[1:0] != 2'b00));
    if (M_mem_rd)
      bad_f3 = (M_funct3 == 3'b011) | (M_funct3[2:1] == 2'b11);
    else
      bad_f3 = M_funct3[2] | (M_funct3[1:0] == 2'b11);
    mem_err = (state == IDLE) & mem_op & (misalign | bad_f3);
    issue   = (state == IDLE) & mem_op & ~(misalign | bad_f3);
    waiting = issue | (state == REQ) | (state == RESP);
  end

  always_comb begin
    st_strb = 4'b1111;
    st_data = M_store_data;
    case (M_funct3[1:0])
      2'b00: begin
        st_strb = 4'b0001 << M_addr[1:0];
        st_data = {4{M_store_data[7:0]}};
      end
      2'b01: begin
        st_strb = M_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{M_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_shift = bus_rdata >> {off_q, 3'b000};
    rd_byte  = rd_shift[7:0];
    rd_half  = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  ld_ext = {24'd0, rd_byte};
      3'b101:  ld_ext = {16'd0, rd_half};
      default: ld_ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wstrb <= 4'd0;
      bus_wdata <= '0;
      ld_data   <= '0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            bus_req   <= 1'b1;
            bus_we    <= ~M_mem_rd;
            bus_addr  <= {M_addr[XLEN-1:2], 2'b00};
            bus_wstrb <= M_mem_rd ? 4'd0 : st_strb;
            bus_wdata <= st_data;
            f3_q      <= M_funct3;
            off_q     <= M_addr[1:0];
            state     <= REQ;
          end
        end
        REQ: begin
          if (bus_ready) begin
            bus_req <= 1'b0;
            state   <= bus_we ? DONE : RESP;
          end
        end
        RESP: begin
          if (bus_rvalid) begin
            ld_data <= ld_ext;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
